// File: rtl/i2c_slave_mem_pkg.sv
// Shared definitions for the I2C memory target: FSM encoding, ACK levels
// and the position of the R/W bit in the device-address byte.
package i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_DEV       = 4'd1;
  localparam state_t ST_DEV_ACK   = 4'd2;
  localparam state_t ST_AHI       = 4'd3;
  localparam state_t ST_AHI_ACK   = 4'd4;
  localparam state_t ST_ALO       = 4'd5;
  localparam state_t ST_ALO_ACK   = 4'd6;
  localparam state_t ST_WDATA     = 4'd7;
  localparam state_t ST_WDATA_ACK = 4'd8;
  localparam state_t ST_RDATA     = 4'd9;
  localparam state_t ST_RDATA_ACK = 4'd10;
  localparam state_t ST_WAIT_STOP = 4'd11;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/i2c_slave_mem_if.sv
// Synchronous byte-wide memory port; the I2C target is the master side,
// the memory array is the slave side.
interface i2c_slave_mem_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock and derives single-cycle
// SCL edge, START and STOP events from one history flop per line.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchronizer chains and history flops; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(scl_i);
      sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(sda_i);
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign sda_o      = sda_s;
  assign scl_rise_o = ~scl_hist_q & scl_s;
  assign scl_fall_o = scl_hist_q & ~scl_s;
  assign start_o    = scl_hist_q & scl_s & sda_hist_q & ~sda_s;
  assign stop_o     = scl_hist_q & scl_s & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave_mem.sv
// EEPROM-style I2C target: bridges random/sequential reads and page writes
// from the bus onto a synchronous memory port. No clock stretching.
module i2c_slave_mem
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [3:0]  DEV_ID      = 4'b1010,
  parameter int unsigned PAGE_BITS   = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      dev_sel,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            sda_oe,
  output logic            busy,
  i2c_slave_mem_if.master mem
);
  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              rd_pend_q, rd_pend_d;

  logic              sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic              match_s;
  logic [15:0]       addr_full_s;
  logic [ADDR_W-1:0] ptr_inc_s, ptr_page_inc_s;
  logic [7:0]        rx_byte_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  assign match_s        = (shift_q[7:4] == DEV_ID) && (shift_q[3:1] == dev_sel);
  assign addr_full_s    = {addr_hi_q, shift_q};
  assign ptr_inc_s      = ptr_q + ADDR_W'(1);
  assign ptr_page_inc_s = {ptr_q[ADDR_W-1:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
  assign rx_byte_s      = {shift_q[6:0], sda_s};

  // Transaction FSM; read data is prefetched on the ACK-bit rise so the MSB
  // is ready to drive on the very next SCL fall.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = rd_pend_q ? mem.mem_rdata : shift_q;
    addr_hi_d   = addr_hi_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rd_pend_d   = 1'b0;
    if (stop_s) begin
      state_d   = ST_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_s) begin
      state_d   = ST_DEV;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_DEV, ST_AHI, ST_ALO, ST_WDATA: begin
          if (scl_rise_s && (bit_cnt_q < 4'd8)) begin
            shift_d   = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if ((state_q == ST_WDATA) && (bit_cnt_q == 4'd7)) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = ptr_q;
              mem_wdata_d = rx_byte_s;
              ptr_d       = ptr_page_inc_s;
            end else begin
              mem_we_d = 1'b0;
            end
          end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b1;
            case (state_q)
              ST_DEV: begin
                if (match_s) begin
                  state_d = ST_DEV_ACK;
                  busy_d  = 1'b1;
                  rw_d    = shift_q[RW_BIT];
                end else begin
                  state_d  = ST_WAIT_STOP;
                  sda_oe_d = 1'b0;
                  busy_d   = 1'b0;
                end
              end
              ST_AHI: begin
                state_d   = ST_AHI_ACK;
                addr_hi_d = shift_q;
              end
              ST_ALO:  state_d = ST_ALO_ACK;
              default: state_d = ST_WDATA_ACK;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_DEV_ACK, ST_AHI_ACK, ST_ALO_ACK, ST_WDATA_ACK: begin
          if (scl_rise_s && (state_q == ST_DEV_ACK) && rw_q) begin
            mem_re_d   = 1'b1;
            mem_addr_d = ptr_q;
            rd_pend_d  = 1'b1;
          end else if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            case (state_q)
              ST_DEV_ACK: begin
                if (rw_q) begin
                  state_d   = ST_RDATA;
                  sda_oe_d  = ~shift_q[7];
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = 4'd1;
                end else begin
                  state_d = ST_AHI;
                end
              end
              ST_AHI_ACK: state_d = ST_ALO;
              ST_ALO_ACK: begin
                state_d = ST_WDATA;
                ptr_d   = addr_full_s[ADDR_W-1:0];
              end
              default: state_d = ST_WDATA;
            endcase
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA: begin
          if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_RDATA_ACK;
          end else if (scl_fall_s) begin
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            state_d = state_q;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_s) begin
            ptr_d = ptr_inc_s;
            if (sda_s == NACK) begin
              state_d = ST_WAIT_STOP;
            end else begin
              mem_re_d   = 1'b1;
              mem_addr_d = ptr_inc_s;
              rd_pend_d  = 1'b1;
            end
          end else if (scl_fall_s) begin
            state_d   = ST_RDATA;
            sda_oe_d  = ~shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d = state_q;
          end
        end
        ST_IDLE, ST_WAIT_STOP: state_d = state_q;
        default:               state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      addr_hi_q   <= 8'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_hi_q   <= addr_hi_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign busy          = busy_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_re    = mem_re_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Directed bench for i2c_slave_mem: a bit-banged bus master, an
// open-drain SDA model and a behavioural memory on the interface.
module tb_i2c_slave_mem;
  import i2c_pkg::*;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [2:0] dev_sel = 3'b001;
  logic       scl_m  = 1'b1;
  logic       sda_m  = 1'b1;
  logic       sda_oe, busy;
  wire        sda_line = sda_m & ~sda_oe;

  i2c_slave_mem_if #(.ADDR_W(16)) mem_if ();

  i2c_slave_mem #(.ADDR_W(16), .DEV_ID(4'b1010), .PAGE_BITS(5), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dev_sel (dev_sel),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .mem     (mem_if)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem_arr [int];
  logic [23:0] wr_log [$];
  logic [15:0] rd_log [$];
  int          oe_cnt = 0, busy_cnt = 0, we_cnt = 0, re_cnt = 0;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'd0;
  logic [7:0]  pre_data = 8'd0;
  int          n_checks = 0, n_errors = 0;

  // Memory model and activity monitors, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (pre_we) mem_arr[int'(pre_addr)] = pre_data;
    if (mem_if.mem_we) begin
      mem_arr[int'(mem_if.mem_addr)] = mem_if.mem_wdata;
      wr_log.push_back({mem_if.mem_addr, mem_if.mem_wdata});
      we_cnt++;
    end
    if (mem_if.mem_re) begin
      mem_if.mem_rdata = mem_arr.exists(int'(mem_if.mem_addr)) ? mem_arr[int'(mem_if.mem_addr)] : 8'h00;
      rd_log.push_back(mem_if.mem_addr);
      re_cnt++;
    end
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk);
    pre_we = 1'b0;
  endtask

  task automatic qwait();
    repeat (5) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); b = sda_line; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic       b;
    logic [7:0] v;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(ack);
    d = v;
  endtask

  initial begin
    logic        ack;
    logic [7:0]  rb0, rb1;
    logic [7:0]  wseq [5];
    logic [15:0] ea;
    int          base, oe0, busy0, we0, re0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", 32'(sda_oe), 32'h0);
    check_eq("rst_busy",   32'(busy), 32'h0);
    check_eq("rst_we",     32'(mem_if.mem_we), 32'h0);
    check_eq("rst_re",     32'(mem_if.mem_re), 32'h0);
    check_eq("rst_addr",   32'(mem_if.mem_addr), 32'h0);
    check_eq("rst_wdata",  32'(mem_if.mem_wdata), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Two-byte write at 0x0010
    wseq = '{8'hA2, 8'h00, 8'h10, 8'h81, 8'h82};
    base = wr_log.size();
    bus_start();
    for (int i = 0; i < 5; i++) begin
      put_byte(wseq[i], ack);
      check_eq($sformatf("wr_ack%0d", i), 32'(ack), 32'(ACK));
    end
    check_eq("wr_busy", 32'(busy), 32'h1);
    bus_stop();
    check_eq("wr_cnt", 32'(wr_log.size() - base), 32'd2);
    if (wr_log.size() >= base + 2) begin
      check_eq("wr_0", 32'(wr_log[base]),     32'h001081);
      check_eq("wr_1", 32'(wr_log[base + 1]), 32'h001182);
    end
    check_eq("wr_busy_stop", 32'(busy), 32'h0);

    // 33-byte page write from 0x001E wraps inside the 32-byte page
    base = wr_log.size();
    bus_start();
    put_byte(8'hA2, ack); put_byte(8'h00, ack); put_byte(8'h1E, ack);
    for (int i = 0; i < 33; i++) put_byte(8'(i), ack);
    bus_stop();
    check_eq("pg_cnt", 32'(wr_log.size() - base), 32'd33);
    if (wr_log.size() >= base + 33) begin
      for (int i = 0; i < 33; i++) begin
        ea = 16'((30 + i) % 32);
        check_eq($sformatf("pg_%0d", i), 32'(wr_log[base + i]), 32'({ea, 8'(i)}));
      end
    end

    // Random read: set address, repeated START, read two bytes
    preload(16'h0020, 8'h5A);
    preload(16'h0021, 8'hA5);
    base = rd_log.size();
    bus_start();
    put_byte(8'hA2, ack); put_byte(8'h00, ack); put_byte(8'h20, ack);
    bus_start();
    put_byte(8'hA3, ack);
    check_eq("rr_dev_ack", 32'(ack), 32'(ACK));
    get_byte(rb0, ACK);
    get_byte(rb1, NACK);
    check_eq("rr_b0", 32'(rb0), 32'h5A);
    check_eq("rr_b1", 32'(rb1), 32'hA5);
    check_eq("rr_state", 32'(dut.state_q), 32'(ST_WAIT_STOP));
    check_eq("rr_busy", 32'(busy), 32'h1);
    bus_stop();
    check_eq("rr_busy_stop", 32'(busy), 32'h0);
    check_eq("rr_rcnt", 32'(rd_log.size() - base), 32'd2);
    if (rd_log.size() >= base + 2) begin
      check_eq("rr_a0", 32'(rd_log[base]),     32'h0020);
      check_eq("rr_a1", 32'(rd_log[base + 1]), 32'h0021);
    end

    // Device-address mismatch: target stays silent
    oe0 = oe_cnt; busy0 = busy_cnt; we0 = we_cnt; re0 = re_cnt;
    bus_start();
    put_byte(8'hA4, ack);
    check_eq("mm_nack", 32'(ack), 32'(NACK));
    put_byte(8'h00, ack);
    put_byte(8'h55, ack);
    bus_stop();
    check_eq("mm_oe",   32'(oe_cnt - oe0), 32'd0);
    check_eq("mm_busy", 32'(busy_cnt - busy0), 32'd0);
    check_eq("mm_we",   32'(we_cnt - we0), 32'd0);
    check_eq("mm_re",   32'(re_cnt - re0), 32'd0);

    // Pointer wrap at 0xFFFF across a current-address read
    preload(16'hFFFF, 8'h3C);
    bus_start();
    put_byte(8'hA2, ack); put_byte(8'hFF, ack); put_byte(8'hFF, ack);
    bus_stop();
    base = rd_log.size();
    bus_start();
    put_byte(8'hA3, ack);
    get_byte(rb0, ACK);
    get_byte(rb1, NACK);
    bus_stop();
    check_eq("pw_rcnt", 32'(rd_log.size() - base), 32'd2);
    if (rd_log.size() >= base + 2) begin
      check_eq("pw_a0", 32'(rd_log[base]),     32'hFFFF);
      check_eq("pw_a1", 32'(rd_log[base + 1]), 32'h0000);
    end
    check_eq("pw_b0",  32'(rb0), 32'h3C);
    check_eq("pw_b1",  32'(rb1), 32'h02);
    check_eq("pw_ptr", 32'(dut.ptr_q), 32'h0001);

    // STOP after four bits of a data byte: nothing is written
    we0 = we_cnt;
    bus_start();
    put_byte(8'hA2, ack); put_byte(8'h00, ack); put_byte(8'h40, ack);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    check_eq("ab_we",    32'(we_cnt - we0), 32'd0);
    check_eq("ab_state", 32'(dut.state_q), 32'(ST_IDLE));
    check_eq("ab_busy",  32'(busy), 32'h0);

    // Asynchronous reset while the target drives a 0 data bit
    bus_start();
    put_byte(8'hA2, ack); put_byte(8'h00, ack); put_byte(8'h20, ack);
    bus_start();
    put_byte(8'hA3, ack);
    check_eq("rs_drive", 32'(sda_oe), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rs_oe",   32'(sda_oe), 32'h0);
    check_eq("rs_busy", 32'(busy), 32'h0);
    check_eq("rs_addr", 32'(mem_if.mem_addr), 32'h0);
    sda_m = 1'b1; scl_m = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rs_state", 32'(dut.state_q), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
